// File: rtl/phased_pkg.sv
// phased_pkg
//   Shared types and arithmetic helpers for phased_step_reg.
//   - op_e      : operation applied to a sample (add or subtract step)
//   - phase_op  : maps a phase index to its operation (even add, odd subtract)
//   - sat_add / sat_sub : width-generic add/sub returning {ovf, result}.
//     Operands are carried at PH_MAXW bits; only the low w bits are
//     meaningful, and the flag sits in bit PH_MAXW of the return value.
package phased_pkg;

  typedef enum logic {OP_ADD, OP_SUB} op_e;

  localparam int PH_MAXW = 32;

  function automatic op_e phase_op(input logic [3:0] p);
    return ((p & 4'd1) != 4'd0) ? OP_SUB : OP_ADD;
  endfunction

  // all-ones in the low w bits
  function automatic logic [PH_MAXW:0] wmask(input int w);
    return ((PH_MAXW+1)'(1) << w) - (PH_MAXW+1)'(1);
  endfunction

  function automatic logic [PH_MAXW:0] sat_add(input logic [PH_MAXW-1:0] x,
                                               input logic [PH_MAXW-1:0] y,
                                               input int                 w,
                                               input logic               sat);
    logic [PH_MAXW:0] sum, m, r;
    logic             c;
    m   = wmask(w);
    sum = {1'b0, x} + {1'b0, y};
    // any bit at or above w is the carry out of a w-bit add
    c   = |(sum & ~m);
    r   = (sat && c) ? m : (sum & m);
    return r | {c, {PH_MAXW{1'b0}}};
  endfunction

  function automatic logic [PH_MAXW:0] sat_sub(input logic [PH_MAXW-1:0] x,
                                               input logic [PH_MAXW-1:0] y,
                                               input int                 w,
                                               input logic               sat);
    logic [PH_MAXW:0] diff, m, r;
    logic             b;
    m    = wmask(w);
    diff = {1'b0, x} - {1'b0, y};
    // a negative result sign-fills every upper bit, including the top one
    b    = diff[PH_MAXW];
    r    = (sat && b) ? '0 : (diff & m);
    return r | {b, {PH_MAXW{1'b0}}};
  endfunction

endpackage

// File: rtl/phased_step_reg_pipe.sv
// phased_pipe
//   Delay line of DEPTH stages carrying valid, data and a per-sample
//   overflow bit. Data/ovf of a stage load only when a valid sample
//   enters it, so the last stage holds its value across bubbles.
//   Ports:
//     clk, rstn       clock, async active-low reset
//     flush           sync clear of every stage (valid, data, ovf)
//     in_vld/in_data/in_ovf    stage input
//     out_vld/out_data/out_ovf last stage contents
module phased_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ovf,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  logic             vld_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             ovf_q  [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        data_q[0] <= in_data;
        ovf_q[0]  <= in_ovf;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          ovf_q[i]  <= ovf_q[i-1];
        end
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  assign out_ovf  = ovf_q[DEPTH-1];

endmodule

// File: rtl/phased_step_reg.sv
// phased_step_reg
//   Phase-sequenced update register. Each accepted sample a is offset by
//   +step on even phases and -step on odd phases, then delivered after
//   LAT clocks (LAT=1: captured on the accepting edge) with a valid tag.
//   Parameters: WIDTH (<= 32), PHASES (2..16), LAT (1..4), SAT (0 wrap, 1 clamp)
//   Ports:
//     clk, rstn   clock, async active-low reset
//     clr         sync clear, wins over en
//     en          accept a/step on this edge
//     a, step     sample and unsigned offset
//     y, y_vld    result and its valid tag
//     phase_o     phase that the next accepted sample will use
//     ovf         sticky overflow/underflow flag
module phased_step_reg
  import phased_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PHASES = 2,
  parameter int LAT    = 1,
  parameter int SAT    = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      en,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          step,
  output logic [WIDTH-1:0]          y,
  output logic                      y_vld,
  output logic [$clog2(PHASES)-1:0] phase_o,
  output logic                      ovf
);

  localparam int PW = $clog2(PHASES);

  logic [PW-1:0]    phase;
  logic             s0_vld;
  logic [WIDTH-1:0] s0_data;
  logic             s0_ovf;
  logic             ovf_seen;
  logic [PH_MAXW:0] res;

  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  always_comb begin
    res = '0;
    if (phase_op(4'(phase)) == OP_ADD)
      res = sat_add(PH_MAXW'(a), PH_MAXW'(step), WIDTH, SAT != 0);
    else
      res = sat_sub(PH_MAXW'(a), PH_MAXW'(step), WIDTH, SAT != 0);
  end

  generate
    if (WIDTH < PH_MAXW) begin : g_res_unused
      logic unused_res_hi;
      assign unused_res_hi = ^res[PH_MAXW-1:WIDTH];
    end
  endgenerate

  // Stage 0: phase counter, arithmetic capture and sticky overflow.
  // ovf_seen remembers flagged samples that already left the output;
  // the live output-stage bit makes ovf rise on the same edge as y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= '0;
      s0_vld   <= 1'b0;
      s0_data  <= '0;
      s0_ovf   <= 1'b0;
      ovf_seen <= 1'b0;
    end else if (clr) begin
      phase    <= '0;
      s0_vld   <= 1'b0;
      s0_data  <= '0;
      s0_ovf   <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      s0_vld   <= en;
      ovf_seen <= ovf_seen | (out_vld & out_ovf);
      if (en) begin
        s0_data <= res[WIDTH-1:0];
        s0_ovf  <= res[PH_MAXW];
        phase   <= (phase == PW'(PHASES-1)) ? '0 : phase + 1'b1;
      end
    end
  end

  generate
    if (LAT == 1) begin : g_direct
      assign out_vld  = s0_vld;
      assign out_data = s0_data;
      assign out_ovf  = s0_ovf;
    end else begin : g_pipe
      phased_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (LAT-1)
      ) u_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (clr),
        .in_vld   (s0_vld),
        .in_data  (s0_data),
        .in_ovf   (s0_ovf),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_ovf  (out_ovf)
      );
    end
  endgenerate

  assign y       = out_data;
  assign y_vld   = out_vld;
  assign phase_o = phase;
  assign ovf     = ovf_seen | (out_vld & out_ovf);

endmodule

// File: tb/tb_phased_step_reg.sv
// tb_phased_step_reg
//   Directed bench driving four configurations from shared stimulus:
//     u0: PHASES=2 LAT=1 SAT=0     u1: PHASES=3 LAT=3 SAT=0
//     u2: PHASES=2 LAT=1 SAT=1     u3: PHASES=2 LAT=2 SAT=0
//   Each step checks only the instance relevant to that scenario.
module tb_phased_step_reg;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr;
  logic       en;
  logic [7:0] a;
  logic [7:0] step;

  logic [7:0] y0, y1, y2, y3;
  logic       v0, v1, v2, v3;
  logic       o0, o1, o2, o3;
  logic       p0, p2, p3;
  logic [1:0] p1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phased_step_reg #(.WIDTH(8), .PHASES(2), .LAT(1), .SAT(0)) u0 (
    .clk(clk), .rstn(rstn), .clr(clr), .en(en), .a(a), .step(step),
    .y(y0), .y_vld(v0), .phase_o(p0), .ovf(o0));
  phased_step_reg #(.WIDTH(8), .PHASES(3), .LAT(3), .SAT(0)) u1 (
    .clk(clk), .rstn(rstn), .clr(clr), .en(en), .a(a), .step(step),
    .y(y1), .y_vld(v1), .phase_o(p1), .ovf(o1));
  phased_step_reg #(.WIDTH(8), .PHASES(2), .LAT(1), .SAT(1)) u2 (
    .clk(clk), .rstn(rstn), .clr(clr), .en(en), .a(a), .step(step),
    .y(y2), .y_vld(v2), .phase_o(p2), .ovf(o2));
  phased_step_reg #(.WIDTH(8), .PHASES(2), .LAT(2), .SAT(0)) u3 (
    .clk(clk), .rstn(rstn), .clr(clr), .en(en), .a(a), .step(step),
    .y(y3), .y_vld(v3), .phase_o(p3), .ovf(o3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; en = 1'b0; a = 8'd0; step = 8'd0;
    #1;
    chk("rst_y",     32'(y0), 0);
    chk("rst_vld",   32'(v0), 0);
    chk("rst_phase", 32'(p0), 0);
    chk("rst_ovf",   32'(o0), 0);
    chk("rst_vld_l3", 32'(v1), 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // alternating add/sub, LAT=1
    a = 8'd10; step = 8'd1; en = 1'b1;
    tick(); chk("alt_y0", 32'(y0), 11); chk("alt_v0", 32'(v0), 1); chk("alt_p0", 32'(p0), 1);
    tick(); chk("alt_y1", 32'(y0), 9);  chk("alt_v1", 32'(v0), 1); chk("alt_p1", 32'(p0), 0);
    tick(); chk("alt_y2", 32'(y0), 11); chk("alt_v2", 32'(v0), 1); chk("alt_p2", 32'(p0), 1);
    tick(); chk("alt_y3", 32'(y0), 9);  chk("alt_v3", 32'(v0), 1); chk("alt_p3", 32'(p0), 0);
    en = 1'b0;
    tick(); chk("alt_hold_y", 32'(y0), 9); chk("alt_hold_v", 32'(v0), 0); chk("alt_hold_p", 32'(p0), 0);
    do_clr();
    chk("clr_y0", 32'(y0), 0);

    // PHASES=3, LAT=3
    a = 8'd20; step = 8'd5; en = 1'b1;
    tick(); chk("l3_v_e1", 32'(v1), 0); chk("l3_p_e1", 32'(p1), 1);
    tick(); chk("l3_v_e2", 32'(v1), 0); chk("l3_p_e2", 32'(p1), 2);
    tick(); chk("l3_y_e3", 32'(y1), 25); chk("l3_v_e3", 32'(v1), 1); chk("l3_p_e3", 32'(p1), 0);
    en = 1'b0;
    tick(); chk("l3_y_e4", 32'(y1), 15); chk("l3_v_e4", 32'(v1), 1);
    tick(); chk("l3_y_e5", 32'(y1), 25); chk("l3_v_e5", 32'(v1), 1);
    tick(); chk("l3_y_e6", 32'(y1), 25); chk("l3_v_e6", 32'(v1), 0); chk("l3_p_e6", 32'(p1), 0);
    do_clr();

    // overflow / saturation
    a = 8'd250; step = 8'd10; en = 1'b1;
    tick();
    chk("add_wrap_y", 32'(y0), 4);   chk("add_wrap_ovf", 32'(o0), 1);
    chk("add_sat_y",  32'(y2), 255); chk("add_sat_ovf",  32'(o2), 1);
    en = 1'b0;
    tick(); chk("ovf_sticky", 32'(o0), 1); chk("ovf_sticky_vld", 32'(v0), 0);
    a = 8'd3; step = 8'd5; en = 1'b1;
    tick();
    chk("sub_wrap_y", 32'(y0), 254); chk("sub_wrap_ovf", 32'(o0), 1);
    chk("sub_sat_y",  32'(y2), 0);   chk("sub_sat_ovf",  32'(o2), 1);
    a = 8'd100; step = 8'd20;
    tick(); chk("sat_plain_y", 32'(y2), 120);
    do_clr();
    chk("clr_ovf0", 32'(o0), 0); chk("clr_ovf2", 32'(o2), 0);
    a = 8'd245; step = 8'd10; en = 1'b1;
    tick();
    chk("edge255_y", 32'(y0), 255); chk("edge255_ovf", 32'(o0), 0);
    chk("edge255_sat_y", 32'(y2), 255); chk("edge255_sat_ovf", 32'(o2), 0);
    do_clr();

    // bubbles with LAT=2: en = 1,0,1
    a = 8'd10; step = 8'd1;
    en = 1'b1; tick(); chk("bub_v_e1", 32'(v3), 0); chk("bub_y_e1", 32'(y3), 0); chk("bub_p_e1", 32'(p3), 1);
    en = 1'b0; tick(); chk("bub_v_e2", 32'(v3), 1); chk("bub_y_e2", 32'(y3), 11); chk("bub_p_e2", 32'(p3), 1);
    en = 1'b1; tick(); chk("bub_v_e3", 32'(v3), 0); chk("bub_y_e3", 32'(y3), 11); chk("bub_p_e3", 32'(p3), 0);
    en = 1'b0; tick(); chk("bub_v_e4", 32'(v3), 1); chk("bub_y_e4", 32'(y3), 9);
    tick(); chk("bub_v_e5", 32'(v3), 0); chk("bub_y_e5", 32'(y3), 9); chk("bub_p_e5", 32'(p3), 0);
    do_clr();

    // clr with en while samples are in flight, LAT=3
    a = 8'd250; step = 8'd10; en = 1'b1;
    tick(); tick(); tick(); tick();
    chk("fl_pre_y", 32'(y1), 240); chk("fl_pre_ovf", 32'(o1), 1); chk("fl_pre_p", 32'(p1), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b0;
    chk("fl_y", 32'(y1), 0); chk("fl_v", 32'(v1), 0); chk("fl_ovf", 32'(o1), 0); chk("fl_p", 32'(p1), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_stale_v", 32'(v1), 0); chk("fl_stale_y", 32'(y1), 0); chk("fl_stale_ovf", 32'(o1), 0);
    end

    // async reset between edges
    a = 8'd10; step = 8'd1; en = 1'b1;
    tick(); chk("ar_pre_y", 32'(y0), 11); chk("ar_pre_p", 32'(p0), 1);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_y", 32'(y0), 0); chk("ar_v", 32'(v0), 0); chk("ar_p", 32'(p0), 0);
    chk("ar_ovf", 32'(o0), 0); chk("ar_l3_p", 32'(p1), 0);
    rstn = 1'b1;
    en = 1'b1;
    tick(); chk("ar_post_y", 32'(y0), 11); chk("ar_post_v", 32'(v0), 1); chk("ar_post_p", 32'(p0), 1);
    en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phased_step_reg.md
# phased_step_reg

Parametrised, phase-sequenced update register: each accepted sample `a` is alternately offset by `+step` and `-step` according to an internal phase counter, then delivered through a configurable-latency pipeline with valid tagging. It is the single-always_ff, counter-driven form of the alternating multi-clock update pattern, and it generalises the plain async-reset capture register. It sits in the procedural-examples datapath as a drop-in registered stage between stimulus and checker.

## Interface
- `WIDTH`, 8, data width of `a`, `step`, `y`.
- `PHASES`, 2, number of phases (2..16); even phases add, odd phases subtract.
- `LAT`, 1, output latency in clocks (1..4).
- `SAT`, 0, 0 = wrap-around arithmetic, 1 = saturate.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear, priority over `en`.
- `en`  in  1  accept `a`/`step` this edge.
- `a`  in  WIDTH  sample.
- `step`  in  WIDTH  unsigned offset.
- `y`  out  WIDTH  result.
- `y_vld`  out  1  `y` updated by a valid sample this cycle.
- `phase_o`  out  $clog2(PHASES)  phase applied to the next accepted sample.
- `ovf`  out  1  sticky overflow/underflow flag.

## Operation
- Reset (`rstn`=0, async): `y`=0, `y_vld`=0, `phase_o`=0, `ovf`=0, all pipeline valids 0.
- Accept: on posedge with `en`=1 and `clr`=0, the result is computed from the current phase p:
  - p even: `a + step`; p odd: `a - step`.
  - Computed at WIDTH+1 bits; carry out (add) or borrow (sub) marks the sample overflowed.
  - SAT=0: low WIDTH bits kept. SAT=1: add clamps to all-ones, sub clamps to 0.
- Phase advances by 1 per accepted sample, wrapping PHASES-1 -> 0. `en`=0: phase holds, a bubble (valid=0) enters the pipeline.
- Pipeline shifts every clock regardless of `en`. `y` loads only when a valid sample reaches the output; otherwise it holds. `y_vld` is the valid bit of the output stage.
- `ovf` sets when an overflowed sample reaches the output, and clears only on reset or `clr`.
- `clr`=1: phase -> 0, all pipeline valids -> 0, `y` -> 0, `y_vld` -> 0, `ovf` -> 0. The sample presented with `clr` is discarded.
- Reset asserted mid-stream drops all in-flight samples immediately. The first accepted sample after reset uses phase 0.

## Timing
- A sample accepted at edge k is visible on `y`/`y_vld` after edge k+LAT-1. LAT=1 gives a single registered capture, updating on the same edge it is accepted.
- Back-to-back `en` sustains one result per clock. Bubbles are preserved in order.
- `phase_o` updates on the accepting edge, so after edge k it shows the phase for the next accept.
- `clr` takes effect on the edge where it is sampled high. Samples accepted at earlier edges but still in flight are flushed.
- Simultaneous `clr` and `en`: `clr` wins, and the phase is not advanced.

## Structure
- Package `phased_pkg`:
  - `typedef enum logic {OP_ADD, OP_SUB} op_e;`
  - phase-to-op function (parity of the phase);
  - width-generic `sat_add`/`sat_sub` functions returning `{ovf, result}`.
- Sub-module `phased_pipe`: valid + data + ovf-bit delay line of depth LAT-1, with async reset and sync flush. It is omitted by generate when LAT=1.
- Top level: phase counter and stage-0 arithmetic in one `always_ff` with a single event control, `@(posedge clk or negedge rstn)`.

## Test plan
- Reset, then `en`=1 for 4 clocks with WIDTH=8, PHASES=2, LAT=1, SAT=0, a=10, step=1 -> `y` = 11, 9, 11, 9; `y_vld`=1 each cycle; `phase_o` = 1, 0, 1, 0.
- PHASES=3, LAT=3, a=20, step=5, 3 accepts -> `y` = 25, 15, 25, starting 2 edges after the first accept; `phase_o` = 0 after the third accept.
- SAT=0, a=250, step=10, phase 0 -> `y`=4, `ovf`=1. Repeat with SAT=1 -> `y`=255, `ovf`=1. Subtract with a=3, step=5 -> 254 (SAT=0) or 0 (SAT=1).
- Pattern `en` = 1,0,1 with LAT=2 -> `y_vld` = 1,0,1 delayed by one clock; `y` holds during the bubble; phase advances only twice.
- `clr` with `en`=1 while 2 samples are in flight (LAT=3) -> next cycle `y`=0, `y_vld`=0, `ovf`=0, `phase_o`=0; no stale results emerge afterwards.
- `rstn` pulsed low between clock edges mid-stream -> outputs go to 0 immediately, without waiting for a clock edge; the first accept after release uses phase 0.
